// File: rtl/gobou_serial_ctrl.sv
// gobou_serial_ctrl: sequencer for the 16-lane output serializer.
// Issues serializer loads and one memory write per shifted lane.
module gobou_serial_ctrl #(
  parameter int CORE   = 16,
  parameter int LWIDTH = 5,
  parameter int AWIDTH = 12,
  parameter int NWIDTH = 16
) (
  input  logic              clk,
  input  logic              xrst,
  input  logic              init,
  input  logic [AWIDTH-1:0] base_addr,
  input  logic [NWIDTH-1:0] total,
  input  logic              req,
  output logic              ready,
  output logic              serial_we,
  output logic              mem_we,
  output logic [AWIDTH-1:0] mem_addr,
  output logic              busy,
  output logic              done
);

  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_LOAD  = 2'd1;
  localparam logic [1:0] S_SHIFT = 2'd2;

  logic [1:0]        state_q, state_d;
  logic              pending_q, pending_d;
  logic [NWIDTH-1:0] remaining_q, remaining_d;
  logic [AWIDTH-1:0] addr_q, addr_d;
  logic [AWIDTH-1:0] maddr_q, maddr_d;
  logic [LWIDTH-1:0] lanes_q, lanes_d;
  logic [LWIDTH-1:0] cnt_q, cnt_d;
  logic              done_q, done_d;

  logic              accept;
  logic              last;
  logic [LWIDTH-1:0] lanes_nxt;

  // remaining is reserved by a whole batch when it is loaded,
  // so it always counts words not yet claimed by any batch
  always_comb begin
    ready = 1'b0;
    unique case (1'b1)
      (state_q == S_IDLE):  ready = (remaining_q != '0);
      (state_q == S_SHIFT): ready = !pending_q && (remaining_q != '0);
      default:              ready = 1'b0;
    endcase
  end

  assign accept    = req && ready;
  assign last      = (state_q == S_SHIFT) &&
                     (cnt_q == lanes_q - LWIDTH'(1));
  assign lanes_nxt = (remaining_q >= NWIDTH'(CORE)) ?
                     LWIDTH'(CORE) : remaining_q[LWIDTH-1:0];

  always_comb begin
    state_d     = state_q;
    pending_d   = pending_q;
    remaining_d = remaining_q;
    addr_d      = addr_q;
    maddr_d     = maddr_q;
    lanes_d     = lanes_q;
    cnt_d       = cnt_q;
    done_d      = 1'b0;
    unique case (1'b1)
      (state_q == S_IDLE): begin
        if (accept) begin
          state_d     = S_LOAD;
          lanes_d     = lanes_nxt;
          remaining_d = remaining_q - NWIDTH'(lanes_nxt);
          cnt_d       = '0;
        end
      end
      (state_q == S_LOAD): begin
        state_d = S_SHIFT;
        maddr_d = addr_q;
        addr_d  = addr_q + AWIDTH'(1);
        cnt_d   = '0;
      end
      (state_q == S_SHIFT): begin
        if (accept) pending_d = 1'b1;
        cnt_d = cnt_q + LWIDTH'(1);
        if (last) begin
          if (pending_q || accept) begin
            state_d     = S_LOAD;
            pending_d   = 1'b0;
            lanes_d     = lanes_nxt;
            remaining_d = remaining_q - NWIDTH'(lanes_nxt);
            cnt_d       = '0;
          end else begin
            state_d = S_IDLE;
            done_d  = (remaining_q == '0);
          end
        end else begin
          maddr_d = addr_q;
          addr_d  = addr_q + AWIDTH'(1);
        end
      end
      default: state_d = S_IDLE;
    endcase
    if (init) begin
      state_d     = S_IDLE;
      pending_d   = 1'b0;
      remaining_d = total;
      addr_d      = base_addr;
      maddr_d     = base_addr;
      lanes_d     = '0;
      cnt_d       = '0;
      done_d      = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (xrst) begin
      state_q     <= S_IDLE;
      pending_q   <= 1'b0;
      remaining_q <= '0;
      addr_q      <= '0;
      maddr_q     <= '0;
      lanes_q     <= '0;
      cnt_q       <= '0;
      done_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      pending_q   <= pending_d;
      remaining_q <= remaining_d;
      addr_q      <= addr_d;
      maddr_q     <= maddr_d;
      lanes_q     <= lanes_d;
      cnt_q       <= cnt_d;
      done_q      <= done_d;
    end
  end

  assign serial_we = (state_q == S_LOAD);
  assign mem_we    = (state_q == S_SHIFT);
  assign mem_addr  = maddr_q;
  assign busy      = (state_q != S_IDLE) || pending_q;
  assign done      = done_q;

endmodule
